// File: rtl/ir_pkg.sv
// ir_pkg: shared opcode constants for the instruction register, controller and ALU
package ir_pkg;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_ADD  = 4'b1101;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b1000;
endpackage

// File: rtl/ir_if.sv
// ir_if: instruction bus bundle; load enable and byte in (IIR, D), eight decode flags out
interface ir_if;
  logic       IIR;
  logic [7:0] D;
  logic       HALT;
  logic       LD;
  logic       ADD;
  logic       SUB;
  logic       AND;
  logic       XOR;
  logic       OR;
  logic       SHL;
  modport master (output IIR, D, input HALT, LD, ADD, SUB, AND, XOR, OR, SHL);
  modport slave  (input IIR, D, output HALT, LD, ADD, SUB, AND, XOR, OR, SHL);
endinterface

// File: rtl/ir_decoder.sv
// ir_decoder: 4-bit opcode -> eight one-hot decode flags (op in; halt..shl out), unmapped codes decode to all-zero
module ir_decoder
  import ir_pkg::*;
(
  input  logic [3:0] op,
  output logic       halt,
  output logic       ld,
  output logic       add,
  output logic       sub,
  output logic       and_op,
  output logic       xor_op,
  output logic       or_op,
  output logic       shl
);
  assign halt   = op == OP_HALT;
  assign ld     = op == OP_LD;
  assign add    = op == OP_ADD;
  assign sub    = op == OP_SUB;
  assign and_op = op == OP_AND;
  assign xor_op = op == OP_XOR;
  assign or_op  = op == OP_OR;
  assign shl    = op == OP_SHL;
endmodule

// File: rtl/ir.sv
// ir: 8-bit instruction register with decode (CLK, RST sync active-high; bus: IIR/D in, decode flags out)
module ir
  import ir_pkg::*;
(
  input logic CLK,
  input logic RST,
  ir_if.slave bus
);
  logic [7:0] ir_q;
  logic       unused_hi;
  always_ff @(posedge CLK)
    if (RST) ir_q <= 8'h00;
    else if (bus.IIR) ir_q <= bus.D;
  // Upper nibble is stored but is don't-care for decode.
  assign unused_hi = &{1'b0, ir_q[7:4]};
  ir_decoder u_dec (
    .op     (ir_q[3:0]),
    .halt   (bus.HALT),
    .ld     (bus.LD),
    .add    (bus.ADD),
    .sub    (bus.SUB),
    .and_op (bus.AND),
    .xor_op (bus.XOR),
    .or_op  (bus.OR),
    .shl    (bus.SHL)
  );
endmodule

// File: tb/tb_ir.sv
// tb_ir: directed self-checking bench for ir
module tb_ir;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  ir_if bus ();
  ir dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] flags;
  assign flags = {bus.HALT, bus.LD, bus.ADD, bus.SUB, bus.AND, bus.XOR, bus.OR, bus.SHL};
  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (flags === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, flags, exp);
    end
  endtask
  task automatic edge_step(input logic r, input logic en, input logic [7:0] d);
    rst = r;
    bus.IIR = en;
    bus.D = d;
    @(posedge clk);
    #1;
  endtask
  logic [7:0] seq [8] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hF9, 8'hF2, 8'hF8};
  logic [7:0] hot [8] = '{8'b1000_0000, 8'b0100_0000, 8'b0010_0000, 8'b0001_0000,
                          8'b0000_1000, 8'b0000_0100, 8'b0000_0010, 8'b0000_0001};
  logic [7:0] nop [9] = '{8'hF0, 8'h01, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hFA, 8'h00};
  initial begin
    rst = 1'b1;
    bus.IIR = 1'b1;
    bus.D = 8'hFF;
    edge_step(1'b1, 1'b1, 8'hFF);
    check("reset_edge1", 8'h00);
    edge_step(1'b1, 1'b1, 8'hFF);
    check("reset_edge2", 8'h00);
    for (int i = 0; i < 8; i++) begin
      edge_step(1'b0, 1'b0, seq[i]);
      check($sformatf("load_disabled_%0d", i), 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      edge_step(1'b0, 1'b1, seq[i]);
      check($sformatf("decode_%02h", seq[i]), hot[i]);
    end
    edge_step(1'b0, 1'b1, 8'hFD);
    check("hold_load_add", 8'b0010_0000);
    edge_step(1'b0, 1'b0, 8'hFF);
    check("hold_edge1", 8'b0010_0000);
    edge_step(1'b0, 1'b0, 8'hFE);
    check("hold_edge2", 8'b0010_0000);
    bus.IIR = 1'b1;
    bus.D = 8'hFF;
    #2;
    check("no_comb_path", 8'b0010_0000);
    for (int i = 0; i < 9; i++) begin
      edge_step(1'b0, 1'b1, nop[i]);
      check($sformatf("nop_%02h", nop[i]), 8'h00);
    end
    edge_step(1'b0, 1'b1, 8'h0F);
    check("upper_dont_care_halt", 8'b1000_0000);
    edge_step(1'b0, 1'b1, 8'h3D);
    check("upper_dont_care_add", 8'b0010_0000);
    edge_step(1'b0, 1'b1, 8'hF2);
    check("prio_load_or", 8'b0000_0010);
    edge_step(1'b1, 1'b1, 8'hFE);
    check("prio_rst_over_iir", 8'h00);
    edge_step(1'b0, 1'b0, 8'hFE);
    check("post_rst_no_load", 8'h00);
    edge_step(1'b0, 1'b1, 8'hFE);
    check("resume_ld", 8'b0100_0000);
    edge_step(1'b1, 1'b0, 8'hFE);
    check("mid_op_reset", 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
